serial_adder: RTL and testbench

- Bit-serial adder, LSB first, built around a full-adder cell made of two half-adder stages plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in with a start pulse.
- Produces one sum bit per clock, then presents the registered WIDTH-bit sum and carry-out with a one-cycle done strobe.
- Sits directly downstream of the combinational half-adder stage. It consumes that stage's sum/carry outputs every bit-cycle and adds the sequencing and storage around them.

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: two half-adder stages plus a carry flip-flop,
// sequenced by a three-state FSM with registered sum/cout and a done strobe.
module serial_adder_ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s1;
  logic             c1;
  logic             s2;
  logic             c2;
  logic             carry_nxt;

  serial_adder_ha u_ha1 (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .sum   (s1),
    .carry (c1)
  );

  serial_adder_ha u_ha2 (
    .a     (s1),
    .b     (carry),
    .sum   (s2),
    .carry (c2)
  );

  assign carry_nxt = c1 | c2;

  // New bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
  always_comb begin
    res_nxt = res_sr >> 1;
    res_nxt[WIDTH-1] = s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= carry_nxt;
          if (cnt == LAST) begin
            sum   <= res_nxt;
            cout  <= carry_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;
  int lat;
  int nbusy;
  logic [7:0] osum;
  logic       ocout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Issue one operation on the chosen instance and measure it.
  task automatic go(input int w, input logic [7:0] x,
                    input logic [7:0] y, input logic c);
    @(posedge clk); #1;
    if (w == 1) begin
      start1 = 1'b1; a1 = x[0]; b1 = y[0]; cin1 = c;
    end else begin
      start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    start8 = 1'b0;
    lat = 0;
    nbusy = (w == 1) ? int'(busy1) : int'(busy8);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (w == 1 ? done1 : done8) begin
        lat = i;
        break;
      end
      if (w == 1 ? busy1 : busy8) nbusy++;
    end
    osum  = (w == 1) ? {7'b0, sum1} : sum8;
    ocout = (w == 1) ? cout1 : cout8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy8, done8, sum8, cout8, busy1, done1, sum1, cout1} !== '0) begin
      errors++;
      $display("FAIL reset: busy8=%b done8=%b sum8=%h cout8=%b busy1=%b done1=%b, want all 0",
               busy8, done8, sum8, cout8, busy1, done1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    go(8, 8'h5A, 8'h33, 1'b0);
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL basic_latency: got %0d want 8", lat);
    end
    checks++;
    if (nbusy != 8) begin
      errors++; $display("FAIL basic_busy: got %0d cycles want 8", nbusy);
    end
    checks++;
    if ({ocout, osum} !== 9'h08D) begin
      errors++; $display("FAIL basic_sum: got %b/%h want 0/8d", ocout, osum);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin
      errors++; $display("FAIL basic_done_width: done=%b want 0", done8);
    end
  endtask

  task automatic test_carry();
    go(8, 8'hFF, 8'h01, 1'b0);
    checks++;
    if ({ocout, osum} !== 9'h100) begin
      errors++; $display("FAIL carry_ff_01: got %b/%h want 1/00", ocout, osum);
    end
    go(8, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if ({ocout, osum} !== 9'h1FF) begin
      errors++; $display("FAIL carry_ff_ff_1: got %b/%h want 1/ff", ocout, osum);
    end
  endtask

  task automatic test_start_busy();
    int ndone;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        checks++;
        if ({cout8, sum8} !== 9'h030) begin
          errors++;
          $display("FAIL busy_ignore_sum: got %b/%h want 0/30", cout8, sum8);
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL busy_ignore_done: got %0d pulses want 1", ndone);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_idle: busy=%b want 0", busy8);
    end
  endtask

  task automatic test_back_to_back();
    int l2;
    int bad;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 8 || sum8 !== 8'h03 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d sum=%h cout=%b want 8/03/0", lat, sum8, cout8);
    end
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap: busy=%b done=%b want 1/0", busy8, done8);
    end
    l2 = 0;
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        l2 = i;
        break;
      end
      if (sum8 !== 8'h03) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_hold: %0d cycles with sum!=03 want 0", bad);
    end
    checks++;
    if (l2 != 8 || {cout8, sum8} !== 9'h101) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d got %b/%h want 8/1/01", l2, cout8, sum8);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    go(8, 8'h11, 8'h22, 1'b0);
    checks++;
    if ({ocout, osum} !== 9'h033) begin
      errors++; $display("FAIL rst_pre: got %b/%h want 0/33", ocout, osum);
    end
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b want 0", busy8, done8, sum8, cout8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone != 0 || sum8 !== 8'h00) begin
      errors++; $display("FAIL rst_abort: activity=%0d sum=%h want 0/00", ndone, sum8);
    end
    go(8, 8'h01, 8'h01, 1'b0);
    checks++;
    if ({ocout, osum} !== 9'h002) begin
      errors++; $display("FAIL rst_after: got %b/%h want 0/02", ocout, osum);
    end
  endtask

  task automatic test_width1();
    go(1, 8'h01, 8'h01, 1'b1);
    checks++;
    if (lat != 1 || {ocout, osum[0]} !== 2'b11) begin
      errors++;
      $display("FAIL w1_basic: lat=%0d got %b%b want 1/11", lat, ocout, osum[0]);
    end
    go(1, 8'h01, 8'h00, 1'b0);
    checks++;
    if (lat != 1 || {ocout, osum[0]} !== 2'b01) begin
      errors++;
      $display("FAIL w1_one: lat=%0d got %b%b want 1/01", lat, ocout, osum[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] x;
    logic [7:0] y;
    logic       c;
    logic [8:0] exp8;
    logic [1:0] exp1;
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 500; n++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        c = 1'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        if (w == 0) begin
          exp8 = {1'b0, x} + {1'b0, y} + {8'b0, c};
          go(8, x, y, c);
          checks++;
          if (lat != 8 || {ocout, osum} !== exp8) begin
            errors++;
            $display("FAIL rand8: %h+%h+%b lat=%0d got %b/%h want 8/%h",
                     x, y, c, lat, ocout, osum, exp8);
          end
        end else begin
          exp1 = {1'b0, x[0]} + {1'b0, y[0]} + {1'b0, c};
          go(1, x, y, c);
          checks++;
          if (lat != 1 || {ocout, osum[0]} !== exp1) begin
            errors++;
            $display("FAIL rand1: %b+%b+%b lat=%0d got %b%b want 1/%b",
                     x[0], y[0], c, lat, ocout, osum[0], exp1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
